// File: rtl/noc_output_arbiter.sv
// Round-robin, packet-locking output arbiter for one router output link.
// Pops one input circular buffer per cycle, holds a grant from HEAD to TAIL
// and forwards every popped flit through a single output register. The
// downstream on/off signal gates every pop.

package params;
    localparam int FLIT_W  = 34;
    localparam int LABEL_W = 2;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    // The flit_label field sits in the top bits of flit_Data_noVC.
    function automatic flit_label_t flit_label(input logic [FLIT_W-1:0] flit);
        return flit_label_t'(flit[FLIT_W-1 -: LABEL_W]);
    endfunction
endpackage

module noc_output_arbiter #(
    parameter int N_INPUTS = 5,
    parameter int PTR_W    = $clog2(N_INPUTS)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_INPUTS-1:0]                    buf_empty_i,
    input  logic [N_INPUTS-1:0][params::FLIT_W-1:0] buf_data_i,
    output logic [N_INPUTS-1:0]                    buf_read_o,
    input  logic                                   on_off_i,
    output logic [params::FLIT_W-1:0]              flit_o,
    output logic                                   flit_valid_o,
    output logic [PTR_W-1:0]                       owner_o,
    output logic                                   locked_o,
    output logic                                   err_o
);
    import params::*;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [PTR_W-1:0]   rr_ptr_r;
    logic [PTR_W-1:0]   next_rr_s;
    logic [PTR_W-1:0]   owner_r;
    logic [PTR_W-1:0]   next_owner_s;

    logic               cand_found_s;
    logic [PTR_W-1:0]   cand_idx_s;
    logic [PTR_W-1:0]   scan_idx_s;

    logic [PTR_W-1:0]   sel_idx_s;
    logic [FLIT_W-1:0]  sel_flit_s;
    flit_label_t        sel_label_s;

    logic               pop_s;
    logic               orphan_s;
    logic [N_INPUTS-1:0] read_s;

    // Index increment that wraps at N_INPUTS, so a non-power-of-two input
    // count never produces an out-of-range index.
    function automatic logic [PTR_W-1:0] inc_mod(input logic [PTR_W-1:0] v);
        logic [PTR_W-1:0] r;
        if (v == PTR_W'(N_INPUTS - 1)) begin
            r = '0;
        end else begin
            r = v + PTR_W'(1);
        end
        return r;
    endfunction

    // Cyclic search for the first non-empty buffer starting at rr_ptr.
    always_comb begin
        cand_found_s = 1'b0;
        cand_idx_s   = '0;
        scan_idx_s   = rr_ptr_r;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (!cand_found_s && !buf_empty_i[scan_idx_s]) begin
                cand_found_s = 1'b1;
                cand_idx_s   = scan_idx_s;
            end else begin
                cand_found_s = cand_found_s;
            end
            scan_idx_s = inc_mod(scan_idx_s);
        end
    end

    // The served input is the lock owner in LOCKED, the candidate in IDLE.
    always_comb begin
        if (state_r == ST_LOCKED) begin
            sel_idx_s = owner_r;
        end else begin
            sel_idx_s = cand_idx_s;
        end
        sel_flit_s  = buf_data_i[sel_idx_s];
        sel_label_s = flit_label(sel_flit_s);
    end

    // Next-state, pointer/owner update and pop decision.
    always_comb begin
        next_state_s = state_r;
        next_rr_s    = rr_ptr_r;
        next_owner_s = owner_r;
        pop_s        = 1'b0;
        orphan_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (on_off_i && cand_found_s) begin
                    pop_s = 1'b1;
                    case (sel_label_s)
                        HEAD: begin
                            next_state_s = ST_LOCKED;
                            next_owner_s = cand_idx_s;
                        end
                        HEADTAIL: begin
                            next_rr_s = inc_mod(cand_idx_s);
                        end
                        BODY, TAIL: begin
                            next_rr_s = inc_mod(cand_idx_s);
                            orphan_s  = 1'b1;
                        end
                        default: begin
                            next_rr_s = inc_mod(cand_idx_s);
                        end
                    endcase
                end else begin
                    pop_s = 1'b0;
                end
            end
            ST_LOCKED: begin
                // A stalled owner is a bubble: no other input is ever served.
                if (on_off_i && !buf_empty_i[owner_r]) begin
                    pop_s = 1'b1;
                    case (sel_label_s)
                        TAIL, HEADTAIL: begin
                            next_state_s = ST_IDLE;
                            next_rr_s    = inc_mod(owner_r);
                        end
                        HEAD, BODY: begin
                            next_state_s = ST_LOCKED;
                        end
                        default: begin
                            next_state_s = ST_LOCKED;
                        end
                    endcase
                end else begin
                    pop_s = 1'b0;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // One-hot pop strobe, suppressed outright while reset is asserted.
    always_comb begin
        read_s = '0;
        if (pop_s && !rst) begin
            read_s[sel_idx_s] = 1'b1;
        end else begin
            read_s = '0;
        end
    end

    assign buf_read_o = read_s;
    assign owner_o    = owner_r;

    // Arbiter state plus the registered output link.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= '0;
            owner_r      <= '0;
            flit_o       <= '0;
            flit_valid_o <= 1'b0;
            locked_o     <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            rr_ptr_r     <= next_rr_s;
            owner_r      <= next_owner_s;
            flit_valid_o <= pop_s;
            locked_o     <= (next_state_s == ST_LOCKED);
            err_o        <= orphan_s;
            if (pop_s) begin
                flit_o <= sel_flit_s;
            end
        end
    end

endmodule

// File: doc/noc_output_arbiter.md
# noc_output_arbiter

Round-robin, packet-locking arbiter that shares one router output link among `N_INPUTS` input `circular_Buffer` instances, where `flit_Data_noVC` comes from `params`. It drives each buffer's `read_i` and forwards the popped flit to the output link register. A grant holds for a whole wormhole packet (HEAD..TAIL). The arbiter respects the downstream on/off flow-control signal.

## Interface
- `N_INPUTS`, default 5: number of competing input buffers (local, N, E, S, W).
- `PTR_W`, default `$clog2(N_INPUTS)`: width of the round-robin pointer and owner index.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `buf_empty_i`  in  N_INPUTS: `buf_empty` of each input buffer.
- `buf_data_i`  in  N_INPUTS x flit_Data_noVC: `output_Data` (head-of-queue flit) of each buffer; valid whenever the buffer is non-empty.
- `buf_read_o`  out  N_INPUTS: one-hot pop strobe, wired to each buffer's `read_i`.
- `on_off_i`  in  1: downstream on/off; 1 = downstream may accept a flit this cycle.
- `flit_o`  out  flit_Data_noVC: registered output flit.
- `flit_valid_o`  out  1: `flit_o` holds a new flit this cycle.
- `owner_o`  out  PTR_W: index of the input holding the lock; meaningful only when `locked_o` = 1.
- `locked_o`  out  1: a packet is in progress.
- `err_o`  out  1: one-cycle pulse when an orphan BODY or TAIL flit is forwarded in IDLE.

## Operation
- Flit type is carried in `flit_label` with values HEAD, BODY, TAIL, HEADTAIL.
- State machine: IDLE, LOCKED. Registers: `state`, `rr_ptr` (PTR_W bits), `owner` (PTR_W bits).
- Candidate in IDLE: the first `i` with `buf_empty_i[i]` = 0, searching cyclically from `rr_ptr` upward and wrapping to 0.
- IDLE, with `on_off_i` = 1 and a candidate `g` present:
  - `buf_read_o[g]` = 1 (combinational).
  - Next edge: `flit_o` <= `buf_data_i[g]` and `flit_valid_o` <= 1.
  - HEAD: go to LOCKED, `owner` <= `g`, `rr_ptr` unchanged.
  - HEADTAIL: stay in IDLE, `rr_ptr` <= `g`+1 mod N_INPUTS.
  - BODY or TAIL (orphan): forward it, stay in IDLE, `rr_ptr` <= `g`+1 mod N_INPUTS, `err_o` pulses.
- LOCKED, with `on_off_i` = 1 and `buf_empty_i[owner]` = 0:
  - `buf_read_o[owner]` = 1 and the flit is forwarded.
  - TAIL or HEADTAIL: go to IDLE, `rr_ptr` <= `owner`+1 mod N_INPUTS.
  - HEAD or BODY: stay in LOCKED.
- LOCKED with the owner buffer empty: bubble. No read, `flit_valid_o` <= 0, lock held. Other inputs are never served.
- `on_off_i` = 0 in either state: `buf_read_o` = 0, `flit_valid_o` <= 0. State, `owner` and `rr_ptr` are unchanged.
- `buf_read_o` is never asserted toward an empty buffer, and never more than one bit at a time.
- `flit_o` holds its last value when `flit_valid_o` = 0.
- Pointer arithmetic is mod N_INPUTS, so an index never reaches N_INPUTS even when N_INPUTS is not a power of two.

## Timing
- Reset values: `state` = IDLE, `rr_ptr` = 0, `owner` = 0, `flit_o` = '0, `flit_valid_o` = 0, `locked_o` = 0, `err_o` = 0.
- While `rst` = 1, `buf_read_o` is forced to 0 combinationally. Reset in mid-packet drops the lock immediately; the next cycle behaves as IDLE.
- Latency: buffer pop (`buf_read_o` high in cycle t) -> `flit_o`/`flit_valid_o` valid in cycle t+1.
- Throughput: one flit per cycle while `on_off_i` = 1 and the served buffer is non-empty.
- `on_off_i` is sampled in the same cycle as the pop. No flit is in flight beyond the output register, so the downstream buffer must assert OFF with at least one slot of slack.
- Re-arbitration after a TAIL costs no dead cycle. In the cycle after the TAIL pop, the arbiter is in IDLE and may pop a new HEAD.
- `locked_o` = (`state` == LOCKED) and `owner_o` = `owner`; both are registered.

## Test plan
- Reset, then all buffers empty for 10 cycles -> `buf_read_o` = 0, `flit_valid_o` = 0 and `rr_ptr` = 0 throughout.
- Inputs 1 and 3 each hold a 3-flit packet (HEAD, BODY, TAIL) with `on_off_i` = 1 -> all of input 1's flits go out first on 3 consecutive cycles, then input 3's packet immediately after, with no interleaving. The final `rr_ptr` is 4.
- Input 4 holds a HEADTAIL and input 0 holds a HEADTAIL, with `rr_ptr` = 4 -> input 4 is served and `rr_ptr` wraps to 0. Input 0 is served next cycle and `rr_ptr` becomes 1.
- Mid-packet, the owner's buffer goes empty for 2 cycles while input 2 is non-empty -> two bubbles, `locked_o` stays 1 and `buf_read_o[2]` is never asserted. After the owner refills, the TAIL is forwarded.
- `on_off_i` is dropped for 3 cycles during a BODY stream -> zero reads and `flit_valid_o` = 0 for those 3 cycles. Streaming resumes with the next BODY and no flit is lost or duplicated.
- Orphan BODY at input 2 in IDLE -> it is forwarded, `err_o` pulses for 1 cycle and `locked_o` stays 0. Then assert `rst` during a locked packet -> all outputs return to their reset values on the next edge.
